pc_call_stack: RTL and testbench

- Parametrised program counter with an integrated return-address stack (LIFO).
- Supports the existing reset, absolute load and auto-increment behaviour, plus PC-relative branch, subroutine call (push return address, jump) and return (pop, jump).
- Sits in the fetch path between the control matrix, which drives its active-low strobes, and the instruction-memory address bus.
- Reports stack depth and sticky overflow/underflow faults to the controller.

---
 rtl/pc_pkg.sv | 36 +++
 rtl/ret_stack.sv | 54 +++++
 rtl/pc_call_stack.sv | 89 ++++++++
 tb/tb_pc_call_stack.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared definitions for the program counter / return-stack block:
// op encoding, strobe priority decode and default widths.
package pc_pkg;

    localparam int DEFAULT_DATA_WIDTH     = 16;
    localparam int DEFAULT_WORD_BYTE_SIZE = 2;

    typedef enum logic [2:0] {
        OP_RESET = 3'd0,
        OP_RET   = 3'd1,
        OP_CALL  = 3'd2,
        OP_LOAD  = 3'd3,
        OP_REL   = 3'd4,
        OP_INC   = 3'd5,
        OP_HOLD  = 3'd6
    } op_t;

    // Active-low strobes; the highest-priority asserted one wins, the rest are ignored.
    function automatic op_t decode_strobes(
        input logic ret_n,
        input logic call_n,
        input logic ld_n,
        input logic rel_n,
        input logic inc_n
    );
        op_t op;
        if (!ret_n)       op = OP_RET;
        else if (!call_n) op = OP_CALL;
        else if (!ld_n)   op = OP_LOAD;
        else if (!rel_n)  op = OP_REL;
        else if (!inc_n)  op = OP_INC;
        else              op = OP_HOLD;
        return op;
    endfunction

endpackage

// File: rtl/ret_stack.sv
// Return-address LIFO: register array written on the falling edge, top-of-stack
// read combinationally from entry depth-1.
module ret_stack #(
    parameter  int DataWidth  = 16,
    parameter  int StackDepth = 8,
    localparam int DepthW     = $clog2(StackDepth + 1),
    localparam int IdxW       = $clog2(StackDepth)
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_push,
    input  logic                 i_pop,
    input  logic [DataWidth-1:0] i_din,
    output logic [DataWidth-1:0] o_top,
    output logic [DepthW-1:0]    o_depth,
    output logic                 o_full,
    output logic                 o_empty
);
    import pc_pkg::*;

    logic [DataWidth-1:0] r_mem [StackDepth];
    logic [DepthW-1:0]    r_depth;
    logic [IdxW-1:0]      w_wr_idx;
    logic [IdxW-1:0]      w_top_idx;
    logic                 w_do_push;
    logic                 w_do_pop;

    assign o_depth   = r_depth;
    assign o_empty   = (r_depth == '0);
    assign o_full    = (r_depth == DepthW'(StackDepth));
    assign w_wr_idx  = IdxW'(r_depth);
    assign w_top_idx = IdxW'(r_depth - DepthW'(1));
    // Pop takes precedence so a combined request never corrupts the top entry.
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && !i_pop && !o_full;
    assign o_top     = o_empty ? '0 : r_mem[w_top_idx];

    always_ff @(negedge i_clk) begin
        if (!i_rst_n) begin
            r_depth <= '0;
        end else if (w_do_pop) begin
            r_depth <= r_depth - DepthW'(1);
        end else if (w_do_push) begin
            r_depth <= r_depth + DepthW'(1);
        end
    end

    always_ff @(negedge i_clk) begin
        if (i_rst_n && w_do_push) begin
            r_mem[w_wr_idx] <= i_din;
        end
    end

endmodule

// File: rtl/pc_call_stack.sv
// Program counter with load, increment, relative branch, call and return,
// backed by a return-address stack with sticky overflow/underflow flags.
module pc_call_stack #(
    parameter int DataWidth    = pc_pkg::DEFAULT_DATA_WIDTH,
    parameter int WordByteSize = pc_pkg::DEFAULT_WORD_BYTE_SIZE,
    parameter int StackDepth   = 8
) (
    input  logic                            Clk,
    input  logic                            Reset,
    input  logic                            LD,
    input  logic                            Inc,
    input  logic                            Rel,
    input  logic                            Call,
    input  logic                            Ret,
    input  logic [DataWidth-1:0]            DIn,
    output logic [DataWidth-1:0]            DOut,
    output logic [$clog2(StackDepth+1)-1:0] Depth,
    output logic                            Empty,
    output logic                            Full,
    output logic                            Overflow,
    output logic                            Underflow
);
    import pc_pkg::*;

    localparam logic [DataWidth-1:0] STEP = DataWidth'(WordByteSize);

    op_t                  w_op;
    logic [DataWidth-1:0] r_pc;
    logic [DataWidth-1:0] w_pc_next;
    logic [DataWidth-1:0] w_top;
    logic [DataWidth-1:0] w_ret_addr;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_empty;
    logic                 r_overflow;
    logic                 r_underflow;

    assign w_op       = !Reset ? OP_RESET : decode_strobes(Ret, Call, LD, Rel, Inc);
    assign w_ret_addr = r_pc + STEP;
    assign w_push     = (w_op == OP_CALL) && !w_full;
    assign w_pop      = (w_op == OP_RET) && !w_empty;

    ret_stack #(
        .DataWidth  (DataWidth),
        .StackDepth (StackDepth)
    ) u_ret_stack (
        .i_clk   (Clk),
        .i_rst_n (Reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (w_ret_addr),
        .o_top   (w_top),
        .o_depth (Depth),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_comb begin
        w_pc_next = r_pc;
        case (w_op)
            OP_RESET: w_pc_next = '0;
            OP_RET:   if (!w_empty) w_pc_next = w_top;
            OP_CALL:  if (!w_full) w_pc_next = DIn;
            OP_LOAD:  w_pc_next = DIn;
            OP_REL:   w_pc_next = r_pc + DIn;
            OP_INC:   w_pc_next = r_pc + STEP;
            default:  w_pc_next = r_pc;
        endcase
    end

    always_ff @(negedge Clk) begin
        r_pc <= w_pc_next;
        if (w_op == OP_RESET) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_op == OP_CALL && w_full)  r_overflow  <= 1'b1;
            if (w_op == OP_RET  && w_empty) r_underflow <= 1'b1;
        end
    end

    assign DOut      = r_pc;
    assign Empty     = w_empty;
    assign Full      = w_full;
    assign Overflow  = r_overflow;
    assign Underflow = r_underflow;

endmodule

// File: tb/tb_pc_call_stack.sv
// Directed bench for pc_call_stack (StackDepth=4): hand-computed PC, depth and
// flag values after each falling edge.
module tb_pc_call_stack;

    localparam int DW = 16;
    localparam int SD = 4;
    localparam int DEPW = $clog2(SD + 1);

    logic            Clk;
    logic            Reset;
    logic            LD;
    logic            Inc;
    logic            Rel;
    logic            Call;
    logic            Ret;
    logic [DW-1:0]   DIn;
    logic [DW-1:0]   DOut;
    logic [DEPW-1:0] Depth;
    logic            Empty;
    logic            Full;
    logic            Overflow;
    logic            Underflow;

    int n_checks = 0;
    int n_errors = 0;

    pc_call_stack #(
        .DataWidth    (DW),
        .WordByteSize (2),
        .StackDepth   (SD)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .LD        (LD),
        .Inc       (Inc),
        .Rel       (Rel),
        .Call      (Call),
        .Ret       (Ret),
        .DIn       (DIn),
        .DOut      (DOut),
        .Depth     (Depth),
        .Empty     (Empty),
        .Full      (Full),
        .Overflow  (Overflow),
        .Underflow (Underflow)
    );

    initial begin
        Clk = 1'b1;
        forever #5 Clk = ~Clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive active-low strobes on the rising edge; sample just after the falling edge.
    task automatic step(input logic rst_n, input logic ret_n, input logic call_n,
                        input logic ld_n, input logic rel_n, input logic inc_n,
                        input logic [DW-1:0] din);
        @(posedge Clk);
        Reset = rst_n;
        Ret   = ret_n;
        Call  = call_n;
        LD    = ld_n;
        Rel   = rel_n;
        Inc   = inc_n;
        DIn   = din;
        @(negedge Clk);
        #1;
    endtask

    task automatic do_reset();            step(0, 1, 1, 1, 1, 1, 16'h0000); endtask
    task automatic do_inc();              step(1, 1, 1, 1, 1, 0, 16'h0000); endtask
    task automatic do_ld(input logic [DW-1:0] d);   step(1, 1, 1, 0, 1, 1, d); endtask
    task automatic do_rel(input logic [DW-1:0] d);  step(1, 1, 1, 1, 0, 1, d); endtask
    task automatic do_call(input logic [DW-1:0] d); step(1, 1, 0, 1, 1, 1, d); endtask
    task automatic do_ret();              step(1, 0, 1, 1, 1, 1, 16'h0000); endtask
    task automatic do_hold();             step(1, 1, 1, 1, 1, 1, 16'hA5A5); endtask

    task automatic expect_state(input string tag, input logic [DW-1:0] pc,
                                input int depth, input logic ovf, input logic unf);
        chk({tag, ".pc"},    32'(DOut),      32'(pc));
        chk({tag, ".depth"}, 32'(Depth),     32'(depth));
        chk({tag, ".empty"}, 32'(Empty),     32'(depth == 0));
        chk({tag, ".full"},  32'(Full),      32'(depth == SD));
        chk({tag, ".ovf"},   32'(Overflow),  32'(ovf));
        chk({tag, ".unf"},   32'(Underflow), 32'(unf));
    endtask

    initial begin
        Reset = 1'b0; Ret = 1'b1; Call = 1'b1; LD = 1'b1; Rel = 1'b1; Inc = 1'b1;
        DIn = '0;

        do_reset();
        expect_state("rst0", 16'h0000, 0, 0, 0);

        // arbitrary activity, including a fault, then reset again
        do_inc();
        do_call(16'h0300);
        do_ret();
        do_ret();
        expect_state("pre_rst", 16'h0004, 0, 0, 1);
        do_reset();
        expect_state("rst1", 16'h0000, 0, 0, 0);

        do_inc();            expect_state("inc1", 16'h0002, 0, 0, 0);
        do_inc();            expect_state("inc2", 16'h0004, 0, 0, 0);
        do_inc();            expect_state("inc3", 16'h0006, 0, 0, 0);
        do_rel(16'hFFFC);    expect_state("rel_back", 16'h0002, 0, 0, 0);
        do_rel(16'h0010);    expect_state("rel_fwd", 16'h0012, 0, 0, 0);
        do_hold();           expect_state("hold", 16'h0012, 0, 0, 0);
        do_ld(16'hFFFE);     expect_state("ld_top", 16'hFFFE, 0, 0, 0);
        do_inc();            expect_state("inc_wrap", 16'h0000, 0, 0, 0);

        do_ld(16'h0100);
        do_call(16'h0200);   expect_state("call1", 16'h0200, 1, 0, 0);
        do_call(16'h0300);   expect_state("call2", 16'h0300, 2, 0, 0);
        do_ret();            expect_state("ret2", 16'h0202, 1, 0, 0);
        do_ret();            expect_state("ret1", 16'h0102, 0, 0, 0);

        do_call(16'h1000);   expect_state("fc1", 16'h1000, 1, 0, 0);
        do_call(16'h2000);   expect_state("fc2", 16'h2000, 2, 0, 0);
        do_call(16'h3000);   expect_state("fc3", 16'h3000, 3, 0, 0);
        do_call(16'h4000);   expect_state("fc4", 16'h4000, 4, 0, 0);
        do_call(16'h5000);   expect_state("fc5_ovf", 16'h4000, 4, 1, 0);
        do_ret();            expect_state("fr4", 16'h3002, 3, 1, 0);
        do_ret();            expect_state("fr3", 16'h2002, 2, 1, 0);
        do_ret();            expect_state("fr2", 16'h1002, 1, 1, 0);
        do_ret();            expect_state("fr1", 16'h0104, 0, 1, 0);

        do_ld(16'h0040);
        do_ret();            expect_state("ret_empty", 16'h0040, 0, 1, 1);
        do_inc();            expect_state("inc_after_unf", 16'h0042, 0, 1, 1);

        // strobe priority
        do_ld(16'h000E);
        do_call(16'h0500);   expect_state("prio_setup", 16'h0500, 1, 1, 1);
        step(1, 0, 0, 0, 1, 0, 16'h0777);
        expect_state("prio_ret", 16'h0010, 0, 1, 1);
        step(1, 1, 0, 0, 1, 0, 16'h0900);
        expect_state("prio_call", 16'h0900, 1, 1, 1);
        do_ret();            expect_state("prio_call_pushed", 16'h0012, 0, 1, 1);
        step(1, 1, 1, 0, 0, 0, 16'h0ABC);
        expect_state("prio_ld", 16'h0ABC, 0, 1, 1);
        step(1, 1, 1, 1, 0, 0, 16'h0004);
        expect_state("prio_rel", 16'h0AC0, 0, 1, 1);

        // back-to-back call/ret with no bubble
        do_call(16'h0C00);   expect_state("b2b_call", 16'h0C00, 1, 1, 1);
        do_ret();            expect_state("b2b_ret", 16'h0AC2, 0, 1, 1);

        // reset mid-sequence discards the pending call
        do_call(16'h0D00);
        do_call(16'h0E00);
        do_call(16'h0F00);   expect_state("mid_pre", 16'h0F00, 3, 1, 1);
        step(0, 1, 0, 1, 1, 1, 16'h0123);
        expect_state("mid_rst", 16'h0000, 0, 0, 0);
        do_call(16'h0222);   expect_state("post_rst_call", 16'h0222, 1, 0, 0);
        do_ret();            expect_state("post_rst_ret", 16'h0002, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
